// File: rtl/axis_tx_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one AXI-Stream TX path between NUM_PORTS sources.
// Optional per-port frame counters (frame_cnt, stats_clr) are built when AXIS_ARB_STATS_EN is defined.
module axis_tx_frame_arbiter #(
  parameter  int NUM_PORTS  = 3,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [IDX_W-1:0]                grant_idx,
  output logic                            busy
`ifdef AXIS_ARB_STATS_EN
  ,
  input  logic                            stats_clr,
  output logic [NUM_PORTS*16-1:0]         frame_cnt
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] grant_next;
  logic             last_hs;
  int               cand;

  assign last_hs = (state == BURST) && s_axis_tvalid[grant_idx] &&
                   s_axis_tlast[grant_idx] && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      grant_idx <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state     <= state_next;
      grant_idx <= grant_next;
    end
  end

  // Scan from lowest to highest priority so the last hit is the nearest port after grant_idx.
  always_comb begin
    state_next = state;
    grant_next = grant_idx;
    cand       = 0;
    case (state)
      IDLE: begin
        for (int k = NUM_PORTS; k >= 1; k--) begin
          cand = (int'(grant_idx) + k) % NUM_PORTS;
          if (s_axis_tvalid[cand]) begin
            grant_next = IDX_W'(cand);
            state_next = BURST;
          end
        end
      end
      BURST: begin
        if (last_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    busy          = 1'b0;
    if (state == BURST) begin
      m_axis_tdata             = s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid            = s_axis_tvalid[grant_idx];
      m_axis_tlast             = s_axis_tlast[grant_idx];
      s_axis_tready[grant_idx] = m_axis_tready;
      busy                     = 1'b1;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [15:0] cnt [NUM_PORTS];

  // Clear wins over a coincident end-of-frame increment.
  always_ff @(posedge aclk) begin
    if (!aresetn || stats_clr) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt[i] <= '0;
      end
    end else if (last_hs) begin
      cnt[grant_idx] <= cnt[grant_idx] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt_out
    assign frame_cnt[gi*16 +: 16] = cnt[gi];
  end
`endif

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Self-checking bench for axis_tx_frame_arbiter: directed vector table, hand sequences,
// and randomized traffic against a round-robin reference model.
module tb_axis_tx_frame_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tlast;
  logic [NP-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic [1:0]       grant_idx;
  logic             busy;
`ifdef AXIS_ARB_STATS_EN
  logic             stats_clr;
  logic [NP*16-1:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_tx_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_idx     (grant_idx),
    .busy          (busy)
`ifdef AXIS_ARB_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .frame_cnt     (frame_cnt)
`endif
  );

  typedef struct {
    logic        rstn;
    logic [2:0]  v;
    logic [2:0]  l;
    logic        mr;
    logic [31:0] d;
    logic        mv;
    logic        ml;
    logic [2:0]  sr;
    logic [1:0]  g;
    logic        bz;
    logic [31:0] md;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rstn, logic [2:0] v, logic [2:0] l, logic mr,
                              logic [31:0] d, logic mv, logic ml, logic [2:0] sr,
                              logic [1:0] g, logic bz, logic [31:0] md);
    vec_t r;
    r.rstn = rstn; r.v = v; r.l = l; r.mr = mr; r.d = d;
    r.mv = mv; r.ml = ml; r.sr = sr; r.g = g; r.bz = bz; r.md = md;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Port i carries d + i*0x100 so the selected source is visible in m_axis_tdata.
  task automatic apply_stimulus(input logic rstn, input logic [2:0] v, input logic [2:0] l,
                                input logic mr, input logic [31:0] d);
    aresetn       = rstn;
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    m_axis_tready = mr;
    for (int i = 0; i < NP; i++) begin
      s_axis_tdata[i*DW +: DW] = d + 32'(i << 8);
    end
  endtask

  task automatic reset_dut();
    repeat (2) begin
      @(negedge aclk);
      apply_stimulus(1'b0, 3'b000, 3'b000, 1'b1, 32'h0);
    end
  endtask

  logic bc [NP];

  task automatic apply_frames();
    @(negedge aclk);
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '1;
    for (int i = 0; i < NP; i++) begin
      s_axis_tlast[i]          = bc[i];
      s_axis_tdata[i*DW +: DW] = 32'(i << 8) | 32'(bc[i]);
    end
    #1;
  endtask

  task automatic advance_frames();
    for (int i = 0; i < NP; i++) begin
      if (s_axis_tready[i]) bc[i] = ~bc[i];
    end
  endtask

  logic [2:0]  rv;
  logic [2:0]  rl;
  logic [31:0] rd [NP];
  logic [2:0]  acc;
  logic        mb;
  int          mg;
  logic [31:0] exp_d;
  logic [2:0]  exp_sr;

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
`ifdef AXIS_ARB_STATS_EN
    stats_clr     = 1'b0;
`endif

    reset_dut();
    #1;
    check_output("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("rst_tready", 32'(s_axis_tready), 32'd0);
    check_output("rst_grant",  32'(grant_idx),     32'd2);
    check_output("rst_busy",   32'(busy),          32'd0);

    // port 1 four-beat frame
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 32'hA0, 0, 0, 3'b000, 2, 0, 32'h0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 32'hA0, 1, 0, 3'b010, 1, 1, 32'h1A0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 32'hA1, 1, 0, 3'b010, 1, 1, 32'h1A1));
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 32'hA2, 1, 0, 3'b010, 1, 1, 32'h1A2));
    tbl.push_back(mk(1, 3'b010, 3'b010, 1, 32'hA3, 1, 1, 3'b010, 1, 1, 32'h1A3));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 32'h00, 0, 0, 3'b000, 1, 0, 32'h0));
    // single-beat frames from ports 2 and 0, rotating past port 1
    tbl.push_back(mk(1, 3'b101, 3'b101, 1, 32'hB0, 0, 0, 3'b000, 1, 0, 32'h0));
    tbl.push_back(mk(1, 3'b101, 3'b101, 1, 32'hB0, 1, 1, 3'b100, 2, 1, 32'h2B0));
    tbl.push_back(mk(1, 3'b101, 3'b101, 1, 32'hB0, 0, 0, 3'b000, 2, 0, 32'h0));
    tbl.push_back(mk(1, 3'b101, 3'b101, 1, 32'hB0, 1, 1, 3'b001, 0, 1, 32'h0B0));
    // port 0 with downstream stalls while others request
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 32'hC0, 0, 0, 3'b000, 0, 0, 32'h0));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 32'hC0, 1, 0, 3'b001, 0, 1, 32'h0C0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 0, 32'hC1, 1, 0, 3'b000, 0, 1, 32'h0C1));
    tbl.push_back(mk(1, 3'b111, 3'b000, 0, 32'hC1, 1, 0, 3'b000, 0, 1, 32'h0C1));
    tbl.push_back(mk(1, 3'b111, 3'b001, 1, 32'hC1, 1, 1, 3'b001, 0, 1, 32'h0C1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 32'h00, 0, 0, 3'b000, 0, 0, 32'h0));
    // port 2 drops tvalid for 5 cycles while port 0 waits
    tbl.push_back(mk(1, 3'b100, 3'b000, 1, 32'hD0, 0, 0, 3'b000, 0, 0, 32'h0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 1, 32'hD0, 1, 0, 3'b100, 2, 1, 32'h2D0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(1, 3'b001, 3'b000, 1, 32'hD1, 0, 0, 3'b100, 2, 1, 32'h0));
    end
    tbl.push_back(mk(1, 3'b101, 3'b100, 1, 32'hD1, 1, 1, 3'b100, 2, 1, 32'h2D1));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 32'h00, 0, 0, 3'b000, 2, 0, 32'h0));
    tbl.push_back(mk(1, 3'b001, 3'b001, 1, 32'hE0, 1, 1, 3'b001, 0, 1, 32'h0E0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 32'h00, 0, 0, 3'b000, 0, 0, 32'h0));

    foreach (tbl[i]) begin
      @(negedge aclk);
      apply_stimulus(tbl[i].rstn, tbl[i].v, tbl[i].l, tbl[i].mr, tbl[i].d);
      #1;
      check_output($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].mv));
      check_output($sformatf("vec%0d_tlast", i),  32'(m_axis_tlast),  32'(tbl[i].ml));
      check_output($sformatf("vec%0d_tready", i), 32'(s_axis_tready), 32'(tbl[i].sr));
      check_output($sformatf("vec%0d_grant", i),  32'(grant_idx),     32'(tbl[i].g));
      check_output($sformatf("vec%0d_busy", i),   32'(busy),          32'(tbl[i].bz));
      if (tbl[i].mv) check_output($sformatf("vec%0d_tdata", i), m_axis_tdata, tbl[i].md);
    end

    // all ports request 2-beat frames back to back
    reset_dut();
    for (int i = 0; i < NP; i++) bc[i] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      apply_frames();
      check_output($sformatf("rr%0d_gap_busy", k),  32'(busy),          32'd0);
      check_output($sformatf("rr%0d_gap_valid", k), 32'(m_axis_tvalid), 32'd0);
      advance_frames();
      apply_frames();
      check_output($sformatf("rr%0d_grant", k),  32'(grant_idx),  32'(k % NP));
      check_output($sformatf("rr%0d_beat0", k),  m_axis_tdata,    32'((k % NP) << 8));
      check_output($sformatf("rr%0d_last0", k),  32'(m_axis_tlast), 32'd0);
      advance_frames();
      apply_frames();
      check_output($sformatf("rr%0d_beat1", k),  m_axis_tdata,    32'((k % NP) << 8) | 32'd1);
      check_output($sformatf("rr%0d_last1", k),  32'(m_axis_tlast), 32'd1);
      advance_frames();
    end

    // reset on the second beat of a port 1 frame
    reset_dut();
    @(negedge aclk); apply_stimulus(1, 3'b010, 3'b000, 1, 32'hF0);
    @(negedge aclk); apply_stimulus(1, 3'b010, 3'b000, 1, 32'hF0);
    @(negedge aclk); apply_stimulus(0, 3'b111, 3'b000, 1, 32'hF1);
    @(negedge aclk); apply_stimulus(1, 3'b111, 3'b000, 1, 32'hF1);
    #1;
    check_output("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("midrst_tready", 32'(s_axis_tready), 32'd0);
    check_output("midrst_grant",  32'(grant_idx),     32'd2);
    check_output("midrst_busy",   32'(busy),          32'd0);
    @(negedge aclk); apply_stimulus(1, 3'b111, 3'b000, 1, 32'hF1);
    #1;
    check_output("midrst_regrant", 32'(grant_idx), 32'd0);
    check_output("midrst_rebusy",  32'(busy),      32'd1);

`ifdef AXIS_ARB_STATS_EN
    reset_dut();
    repeat (3) begin
      @(negedge aclk); apply_stimulus(1, 3'b010, 3'b010, 1, 32'h55);
      @(negedge aclk); apply_stimulus(1, 3'b010, 3'b010, 1, 32'h55);
    end
    @(negedge aclk); apply_stimulus(1, 3'b000, 3'b000, 1, 32'h0);
    #1;
    check_output("stats_port1", 32'(frame_cnt[31:16]), 32'd3);
    check_output("stats_port0", 32'(frame_cnt[15:0]),  32'd0);
    @(negedge aclk); apply_stimulus(1, 3'b010, 3'b010, 1, 32'h66);
    @(negedge aclk); apply_stimulus(1, 3'b010, 3'b010, 1, 32'h66); stats_clr = 1'b1;
    @(negedge aclk); apply_stimulus(1, 3'b000, 3'b000, 1, 32'h0);  stats_clr = 1'b0;
    #1;
    check_output("stats_clr_wins", 32'(frame_cnt[31:16]), 32'd0);
`endif

    // randomized traffic against the round-robin model
    reset_dut();
    mb  = 1'b0;
    mg  = NP - 1;
    rv  = '0;
    rl  = '0;
    acc = '0;
    for (int i = 0; i < NP; i++) rd[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge aclk);
      aresetn       = ($urandom_range(0, 199) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NP; i++) begin
        if (!(rv[i] && !acc[i])) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          rl[i] = ($urandom_range(0, 2) == 0);
          rd[i] = $urandom;
        end
        s_axis_tdata[i*DW +: DW] = rd[i];
      end
      s_axis_tvalid = rv;
      s_axis_tlast  = rl;
      #1;
      exp_sr = '0;
      exp_d  = '0;
      if (mb) begin
        exp_sr[mg] = m_axis_tready;
        exp_d      = rd[mg];
      end
      check_output("rnd_tvalid", 32'(m_axis_tvalid), 32'(mb && rv[mg]));
      check_output("rnd_tlast",  32'(m_axis_tlast),  32'(mb && rl[mg]));
      check_output("rnd_tready", 32'(s_axis_tready), 32'(exp_sr));
      check_output("rnd_grant",  32'(grant_idx),     32'(mg));
      check_output("rnd_busy",   32'(busy),          32'(mb));
      if (mb && rv[mg]) check_output("rnd_tdata", m_axis_tdata, exp_d);
      acc = rv & s_axis_tready;
      if (!aresetn) begin
        mb = 1'b0;
        mg = NP - 1;
        acc = '0;
      end else if (!mb) begin
        for (int k = 1; k <= NP; k++) begin
          if (rv[(mg + k) % NP]) begin
            mg = (mg + k) % NP;
            mb = 1'b1;
            break;
          end
        end
      end else if (rv[mg] && rl[mg] && m_axis_tready) begin
        mb = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
